// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port synchronous RAM between two requesters. One
//   request is latched at a time and sequenced through IDLE -> ACCESS
//   (-> RDWAIT for reads) -> IDLE. Read data comes back on the shared
//   registered rdata bus with a per-requester one-cycle rvalid pulse.
//
//   Configuration macro: ARB_FIXED_PRIO_EN
//     undefined (default) : ties are resolved round-robin (requester 0 wins
//                           the first tie after reset)
//     defined             : requester 0 always wins a tie, no pointer kept
//
//   Handshake: a requester raises req with we/addr/wdata stable and holds
//   them until its gnt pulse; gnt means the transaction has been captured
//   and is on the RAM pins this cycle, so req may drop from the next cycle.
//   Requests are only sampled in IDLE. A read's result is signalled by a
//   single-cycle rvalid; there is no back-pressure on read data.
//
//   The FSM state is exported on the state output for observation.
module ram_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;

  // Latched transaction: owner 0/1, operation, address and write data.
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  // take: a request is being accepted at the end of this IDLE cycle.
  // pick: which requester wins it.
  logic                take;
  logic                pick;

`ifdef ARB_FIXED_PRIO_EN

  // Winner selection: requester 0 has absolute priority on a tie.
  always_comb begin
    take = (state_q == IDLE) && (req0 || req1);
    pick = !req0;
  end

`else

  // last_q = 1 means requester 1 was served last, so 0 wins the next tie.
  logic                last_q;

  // Winner selection: a lone requester wins; on a tie the one not served last.
  always_comb begin
    take = (state_q == IDLE) && (req0 || req1);
    if (req0 && req1) begin
      pick = !last_q;
    end else begin
      pick = req1;
    end
  end

  // Round-robin pointer, moved to the winner on every accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (take) begin
      last_q <= pick;
    end
  end

`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: writes finish after ACCESS, reads take one extra
  // cycle in RDWAIT for the RAM's registered output.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transaction capture. The address/data registers double as the RAM
  // address/data drivers, so they hold their last value outside ACCESS.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      owner_q <= pick;
      if (pick) begin
        we_q    <= we1;
        addr_q  <= addr1;
        wdata_q <= wdata1;
      end else begin
        we_q    <= we0;
        addr_q  <= addr0;
        wdata_q <= wdata0;
      end
    end
  end

  // Read return: capture RAM output during RDWAIT, flag the owner next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata   <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= (state_q == RDWAIT) && !owner_q;
      rvalid1 <= (state_q == RDWAIT) && owner_q;
      if (state_q == RDWAIT) begin
        rdata <= ram_q;
      end
    end
  end

  // Output decode from state and the latched transaction.
  always_comb begin
    gnt0      = (state_q == ACCESS) && !owner_q;
    gnt1      = (state_q == ACCESS) && owner_q;
    ram_wren  = (state_q == ACCESS) && we_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    busy      = (state_q != IDLE);
    state     = state_q;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares one single-port 16×8 synchronous RAM (the `altsyncram`-style `ram1` macro used in the memory lab) between two independent masters, such as the switch-input write path and the seven-segment display read path. It latches one request at a time, sequences the RAM address/data/write-enable through a small FSM, and returns read data with a valid pulse. Ties are resolved round-robin. It sits between the requesters and the RAM instance in the memory top level.

## Interface
- `ADDR_W`, 4, RAM address width (16 words)
- `DATA_W`, 8, RAM word width
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req0` / `req1`  in  1  access request from requester 0 / 1; held until the matching `gnt`
- `we0` / `we1`  in  1  1 = write, 0 = read; held with `req`
- `addr0` / `addr1`  in  ADDR_W  word address; held with `req`
- `wdata0` / `wdata1`  in  DATA_W  write data; held with `req`
- `gnt0` / `gnt1`  out  1  one-cycle pulse: this requester's transaction is being issued to the RAM
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse: `rdata` holds this requester's read result
- `rdata`  out  DATA_W  registered read data, shared by both requesters
- `ram_addr`  out  ADDR_W  to RAM `address`
- `ram_wdata`  out  DATA_W  to RAM `data`
- `ram_wren`  out  1  to RAM `wren`, active-high
- `ram_q`  in  DATA_W  from RAM `q`; valid one cycle after the address is presented
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE: if either `req` is high at a clock edge, the FSM selects a winner, latches its `we`/`addr`/`wdata` plus an owner bit, and moves to ACCESS. If no request is high, it stays in IDLE.
- Arbitration:
  - If only one requester is asserting, it wins.
  - If both are asserting, the winner is the requester not served last.
  - The last-served pointer updates on every grant and resets to "1 served last", so requester 0 wins the first tie.
- ACCESS:
  - `ram_addr`, `ram_wdata` and `ram_wren` are driven from the latched values.
  - `gnt` for the owner is high for this single cycle.
  - If the latched op is a write, the next state is IDLE; if it is a read, the next state is RDWAIT.
- RDWAIT: `ram_q` is captured into `rdata` at the end of the cycle, and the owner's `rvalid` is set for the following cycle. The next state is IDLE.
- Outside ACCESS, `ram_wren` is 0. `ram_addr` and `ram_wdata` hold their last values.
- A captured transaction always completes. `req` is sampled only in IDLE, so dropping `req` after capture has no effect.
- `rdata` holds its value until the next read completes.

## Timing
- Reset values (`rst_n` low at an edge): state IDLE; `gnt*`, `rvalid*`, `ram_wren` and `busy` are 0; `rdata`, `ram_addr` and `ram_wdata` are 0; pointer = 1.
- Reset asserted during ACCESS or RDWAIT aborts the transaction. No `rvalid` is issued. A write that was already in ACCESS at that edge has been presented to the RAM and is not undone.
- Write sequence, with request seen at edge N:
  - ACCESS in cycle N+1; `gnt` high and `ram_wren` high in that cycle.
  - IDLE in N+2. A new request can be sampled at the end of N+2.
  - Throughput: one write per 2 cycles.
- Read sequence, with request seen at edge N:
  - ACCESS in N+1 (`gnt` high).
  - RDWAIT in N+2 (`ram_q` valid).
  - `rvalid` high with valid `rdata` in N+3, while the FSM is already in IDLE.
  - Throughput: one read per 3 cycles.
- `rvalid` for the previous read and acceptance of a new request may coincide, in cycle N+3.
- Same-address write followed by read: the read returns the newly written data, because transactions never overlap.

## Configuration
- `ARB_FIXED_PRIO_EN` defined: requester 0 always wins a tie; the round-robin pointer is removed.
- `ARB_FIXED_PRIO_EN` undefined (default): round-robin as specified above.

## Test plan
- Reset, then `req0`=1, `we0`=1, `addr0`=3, `wdata0`=8'h2A: `gnt0` pulses one cycle later with `ram_wren`=1 and `ram_addr`=3. Then `req0`=1, `we0`=0, `addr0`=3: `rvalid0` pulses 3 cycles after the request is sampled, with `rdata`=8'h2A.
- `req0` and `req1` both held high for writes to addresses 1 and 2: grants go 0, 1, 0, 1 on alternate ACCESS cycles, one grant every 2 cycles. With `ARB_FIXED_PRIO_EN` defined, only `gnt0` is issued.
- `req1` read of address 5 (preloaded 8'h17) while `req0` is idle: `gnt1` in cycle N+1, `busy` high for 2 cycles, `rvalid1` with `rdata`=8'h17 in N+3; `rvalid0` stays 0.
- Read captured, then `rst_n`=0 during RDWAIT: no `rvalid` is issued; all outputs are 0 the next cycle; the first tie after reset grants requester 0.
- Back-to-back reads from both requesters (address 0 = 8'h0D, address 7 = 8'hF0): `rvalid0` then `rvalid1` with the matching `rdata`, spaced 3 cycles apart; `ram_wren` never asserts.
